rd_seq_ctrl: RTL and testbench

RD_SEQ_CTRL -- requirements
Module: rd_seq_ctrl

---
 rtl/rd_seq_pkg.sv | 45 ++++
 rtl/rd_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_rd_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rd_seq_pkg.sv
// Shared definitions for the readout sequencer: state encoding, default
// timing values and the memory-depth address mask.
package rd_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LATCH  = 3'd1,
      S_CALC   = 3'd2,
      S_GRST   = 3'd3,
      S_SETTLE = 3'd4,
      S_READ   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam int RST_CYC_DEF  = 4;
   localparam int WAIT_CYC_DEF = 3;

   // Low-N-bit mask matching the read address generator's depth encoding.
   function automatic logic [27:0] depth_mask(input logic [3:0] code);
      logic [4:0]  n;
      logic [28:0] m;
      case (code)
         4'b1111: n = 5'd28;
         4'b1110: n = 5'd27;
         4'b1101: n = 5'd26;
         4'b1100: n = 5'd25;
         4'b1011: n = 5'd24;
         4'b1010: n = 5'd23;
         4'b1001: n = 5'd22;
         4'b1000: n = 5'd21;
         4'b0111: n = 5'd20;
         4'b0110: n = 5'd19;
         4'b0101: n = 5'd17;
         4'b0100: n = 5'd16;
         4'b0011: n = 5'd14;
         4'b0010: n = 5'd12;
         4'b0001: n = 5'd10;
         4'b0000: n = 5'd8;
         default: n = 5'd20;
      endcase
      m = (29'd1 << n) - 29'd1;
      return m[27:0];
   endfunction

endpackage

// File: rtl/rd_seq_ctrl.sv
// Readout sequencer: latches readout parameters, computes the generator start
// address, pulses the generator reset, waits for it to settle, then gates
// rd_en on FIFO back-pressure until the generator reports completion.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start
// S_LATCH  | capture trig_addr / pre_depth / num_rd / depth_ctrl
// S_CALC   | compute masked start address, skip readout if num_rd < 2
// S_GRST   | hold generator reset low for RST_CYC cycles
// S_SETTLE | generator out of reset, wait WAIT_CYC cycles
// S_READ   | rd_en follows !fifo_afull && !gen_read_stop
// S_DONE   | one-cycle done pulse
module rd_seq_ctrl
   import rd_seq_pkg::*;
#(
   parameter int WAIT_CYC = WAIT_CYC_DEF,
   parameter int RST_CYC  = RST_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [27:0] trig_addr,
   input  logic [27:0] pre_depth,
   input  logic [27:0] num_rd,
   input  logic [3:0]  depth_ctrl,
   input  logic        fifo_afull,
   input  logic        gen_read_stop,
   output logic        gen_rst_n,
   output logic [28:0] addr_init_rd,
   output logic [27:0] num_rd_o,
   output logic [3:0]  depth_ctrl_o,
   output logic        rd_en,
   output logic        busy,
   output logic        done
);

   // Down-counter reload values; the terminal count is zero, so load N-1.
   localparam logic [7:0] RST_LD  = 8'(RST_CYC - 1);
   localparam logic [7:0] WAIT_LD = 8'(WAIT_CYC - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic        w_abort;

   logic [27:0] r_trig;
   logic [27:0] r_pre;
   logic [27:0] r_num;
   logic [3:0]  r_depth;
   logic [27:0] r_addr;
   logic        r_gen_rst_n;
   logic        r_rd_en;
   logic        r_busy;
   logic        r_done;

   // State and phase-counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and counter sequencing; abort overrides every transition.
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_abort   = abort && (r_state != S_IDLE);
      case (r_state)
         S_IDLE:   if (start) w_next = S_LATCH;
         S_LATCH:  w_next = S_CALC;
         S_CALC: begin
            if (r_num < 28'd2) begin
               w_next = S_DONE;
            end else begin
               w_next    = S_GRST;
               w_cnt_nxt = RST_LD;
            end
         end
         S_GRST: begin
            if (r_cnt == 8'd0) begin
               w_next    = S_SETTLE;
               w_cnt_nxt = WAIT_LD;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_SETTLE: begin
            if (r_cnt == 8'd0) w_next = S_READ;
            else               w_cnt_nxt = r_cnt - 8'd1;
         end
         S_READ:   if (gen_read_stop) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (w_abort) begin
         w_next    = S_IDLE;
         w_cnt_nxt = '0;
      end
   end

   // Registered outputs decoded from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_trig      <= '0;
         r_pre       <= '0;
         r_num       <= '0;
         r_depth     <= '0;
         r_addr      <= '0;
         r_gen_rst_n <= 1'b0;
         r_rd_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (r_state == S_LATCH) begin
            r_trig  <= trig_addr;
            r_pre   <= pre_depth;
            r_num   <= num_rd;
            r_depth <= depth_ctrl;
         end
         if (r_state == S_CALC) begin
            r_addr <= (r_trig - r_pre) & depth_mask(r_depth);
         end
         r_gen_rst_n <= !((w_next == S_GRST) || w_abort);
         r_rd_en     <= (w_next == S_READ) && !fifo_afull && !gen_read_stop;
         r_busy      <= (w_next != S_IDLE);
         r_done      <= (w_next == S_DONE);
      end
   end

   assign gen_rst_n    = r_gen_rst_n;
   assign addr_init_rd = {1'b0, r_addr};
   assign num_rd_o     = r_num;
   assign depth_ctrl_o = r_depth;
   assign rd_en        = r_rd_en;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_rd_seq_ctrl.sv
// Directed bench for rd_seq_ctrl with hand-computed expectations.
module tb_rd_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [27:0] trig_addr;
   logic [27:0] pre_depth;
   logic [27:0] num_rd;
   logic [3:0]  depth_ctrl;
   logic        fifo_afull;
   logic        gen_read_stop;
   logic        gen_rst_n;
   logic [28:0] addr_init_rd;
   logic [27:0] num_rd_o;
   logic [3:0]  depth_ctrl_o;
   logic        rd_en;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   rd_seq_ctrl #(.WAIT_CYC(3), .RST_CYC(4)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .trig_addr     (trig_addr),
      .pre_depth     (pre_depth),
      .num_rd        (num_rd),
      .depth_ctrl    (depth_ctrl),
      .fifo_afull    (fifo_afull),
      .gen_read_stop (gen_read_stop),
      .gen_rst_n     (gen_rst_n),
      .addr_init_rd  (addr_init_rd),
      .num_rd_o      (num_rd_o),
      .depth_ctrl_o  (depth_ctrl_o),
      .rd_en         (rd_en),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present parameters with a one-cycle start; returns in the LATCH cycle.
   task automatic launch(input logic [27:0] t, input logic [27:0] p,
                         input logic [27:0] n, input logic [3:0] d);
      trig_addr  = t;
      pre_depth  = p;
      num_rd     = n;
      depth_ctrl = d;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   initial begin
      int n;
      int m;
      int lows;

      rst = 1'b0; start = 1'b0; abort = 1'b0;
      trig_addr = '0; pre_depth = '0; num_rd = '0; depth_ctrl = '0;
      fifo_afull = 1'b0; gen_read_stop = 1'b0;

      repeat (3) step();
      chk("rst_rd_en",     32'(rd_en), 0);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_done",      32'(done), 0);
      chk("rst_gen_rst_n", 32'(gen_rst_n), 0);
      chk("rst_addr",      32'(addr_init_rd), 0);
      chk("rst_num",       32'(num_rd_o), 0);
      chk("rst_depth",     32'(depth_ctrl_o), 0);

      rst = 1'b1;
      step();
      chk("rel_gen_rst_n", 32'(gen_rst_n), 1);
      chk("rel_busy",      32'(busy), 0);

      // Full readout with a 10-cycle FIFO stall.
      launch(28'h0000100, 28'h40, 28'h400, 4'b1111);
      chk("a_busy_latch", 32'(busy), 1);
      step();
      chk("a_num_o",   32'(num_rd_o), 'h400);
      chk("a_depth_o", 32'(depth_ctrl_o), 'hF);
      step();
      chk("a_addr",    32'(addr_init_rd), 'hC0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (gen_rst_n !== 1'b0) break;
         n++;
         step();
      end
      chk("a_grst_len", 32'(n), 4);
      m = 0;
      for (int i = 0; i < 20; i++) begin
         if (rd_en === 1'b1) break;
         chk("a_settle_grst_n", 32'(gen_rst_n), 1);
         m++;
         step();
      end
      chk("a_settle_len", 32'(m), 3);
      step();
      chk("a_rd_en_run", 32'(rd_en), 1);

      fifo_afull = 1'b1;
      chk("a_stall_c1", 32'(rd_en), 1);
      lows = 0;
      for (int k = 2; k <= 12; k++) begin
         step();
         if (k == 11) fifo_afull = 1'b0;
         if (k <= 11 && rd_en === 1'b0) lows++;
         if (k == 12) chk("a_stall_resume", 32'(rd_en), 1);
      end
      chk("a_stall_lows", 32'(lows), 10);

      gen_read_stop = 1'b1;
      step();
      gen_read_stop = 1'b0;
      chk("a_done",       32'(done), 1);
      chk("a_done_rd_en", 32'(rd_en), 0);
      step();
      chk("a_done_clr",   32'(done), 0);
      chk("a_idle_busy",  32'(busy), 0);

      // num_rd below 2 skips the readout; address wraps inside 8-bit mask.
      launch(28'h10, 28'h20, 28'h1, 4'b0000);
      step();
      chk("b_no_done_early", 32'(done), 0);
      step();
      chk("b_done_3cyc", 32'(done), 1);
      chk("b_rd_en",     32'(rd_en), 0);
      chk("b_gen_rst_n", 32'(gen_rst_n), 1);
      chk("b_addr",      32'(addr_init_rd), 'hF0);
      step();
      chk("b_done_clr",  32'(done), 0);

      // num_rd zero with the 17-bit mask.
      launch(28'h5, 28'h10, 28'h0, 4'b0101);
      step();
      step();
      chk("c_done",  32'(done), 1);
      chk("c_addr",  32'(addr_init_rd), 'h1FFF5);
      step();

      // Abort during SETTLE.
      launch(28'h200, 28'h0, 28'h2, 4'b0111);
      repeat (6) step();
      chk("d_settle_grst_n", 32'(gen_rst_n), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("d_ab_busy",  32'(busy), 0);
      chk("d_ab_grstn", 32'(gen_rst_n), 0);
      chk("d_ab_done",  32'(done), 0);
      step();
      chk("d_ab_grstn2", 32'(gen_rst_n), 1);
      chk("d_ab_done2",  32'(done), 0);

      // Abort during READ, together with gen_read_stop.
      launch(28'h200, 28'h0, 28'h2, 4'b0111);
      repeat (9) step();
      chk("e_rd_en", 32'(rd_en), 1);
      abort = 1'b1;
      gen_read_stop = 1'b1;
      step();
      abort = 1'b0;
      gen_read_stop = 1'b0;
      chk("e_ab_busy",  32'(busy), 0);
      chk("e_ab_done",  32'(done), 0);
      chk("e_ab_rd_en", 32'(rd_en), 0);
      chk("e_ab_grstn", 32'(gen_rst_n), 0);
      step();
      chk("e_ab_done2",  32'(done), 0);
      chk("e_ab_grstn2", 32'(gen_rst_n), 1);

      // Reset mid-READ with start held high.
      launch(28'h300, 28'h100, 28'h8, 4'b1000);
      repeat (9) step();
      chk("f_rd_en", 32'(rd_en), 1);
      rst = 1'b0;
      start = 1'b1;
      step();
      chk("f_rst_rd_en", 32'(rd_en), 0);
      chk("f_rst_busy",  32'(busy), 0);
      chk("f_rst_grstn", 32'(gen_rst_n), 0);
      chk("f_rst_addr",  32'(addr_init_rd), 0);
      chk("f_rst_num",   32'(num_rd_o), 0);
      step();
      chk("f_rst_hold_busy", 32'(busy), 0);
      rst = 1'b1;
      start = 1'b0;
      step();
      chk("f_rel_grstn", 32'(gen_rst_n), 1);
      chk("f_rel_busy",  32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
